// File: rtl/mlp_trainer.sv
// Epoch sequencer for an MLP: holds a small labelled dataset, presents each sample,
// pulses one weight update per sample and publishes the mean binary cross-entropy per epoch.
module mlp_trainer #(
    parameter int inputs        = 2,
    parameter int outputs       = 1,
    parameter int samples       = 4,
    parameter int settle_cycles = 2,
    localparam int idx_w        = $clog2(samples + 1),
    localparam int sidx_w       = (samples > 1) ? $clog2(samples) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [idx_w-1:0]  load_idx,
    input  real               load_values [inputs],
    input  real               load_expected [outputs],
    input  logic              start,
    input  logic [15:0]       epochs,
    input  logic              train_en,
    input  real               lr_in,
    output real               mlp_values [inputs],
    output real               mlp_expected [outputs],
    output logic              mlp_training,
    output real               mlp_learning_rate,
    input  real               mlp_prediction [outputs],
    output logic              busy,
    output logic              done,
    output logic [sidx_w-1:0] sample_idx,
    output logic [15:0]       epoch_count,
    output real               epoch_loss,
    output logic              loss_valid
);

    localparam int  cnt_w   = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
    localparam real epsilon = 1.0e-7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESENT   = 3'd1,
        CAPTURE   = 3'd2,
        UPDATE    = 3'd3,
        ADVANCE   = 3'd4,
        EPOCH_END = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t            state_r;
    logic [cnt_w-1:0]  settle_r;
    logic [15:0]       epochs_r;
    logic              train_en_r;
    real               acc_r;
    real               ds_values_r [samples][inputs];
    real               ds_expected_r [samples][outputs];

    logic              last_sample_s;
    logic              epochs_done_s;
    logic              enter_present_s;
    logic [sidx_w-1:0] present_idx_s;
    logic              load_ok_s;
    real               capture_sum_s;

    // Binary cross-entropy of one output; epsilon keeps the logs finite at p = 0 or 1.
    function automatic real bce_term(input real e, input real p);
        return -((e * $ln(p + epsilon)) + ((1.0 - e) * $ln(1.0 - p + epsilon)));
    endfunction

    // Decode which transitions (re)enter PRESENT and which dataset row they present.
    always_comb begin
        last_sample_s   = (sample_idx == sidx_w'(samples - 1));
        epochs_done_s   = (({1'b0, epoch_count} + 17'd1) >= {1'b0, epochs_r});
        load_ok_s       = load_en && ((state_r == IDLE) || (state_r == DONE))
                          && (int'(load_idx) < samples);
        enter_present_s = 1'b0;
        present_idx_s   = '0;
        case (state_r)
            IDLE: begin
                enter_present_s = start && (epochs != 16'd0);
            end
            ADVANCE: begin
                enter_present_s = !last_sample_s;
                present_idx_s   = sample_idx + sidx_w'(1);
            end
            EPOCH_END: begin
                enter_present_s = !epochs_done_s;
            end
            default: begin
                enter_present_s = 1'b0;
            end
        endcase
    end

    // Sum of per-output loss terms for the sample currently held.
    always_comb begin
        capture_sum_s = 0.0;
        for (int o = 0; o < outputs; o++) begin
            capture_sum_s = capture_sum_s + bce_term(mlp_expected[o], mlp_prediction[o]);
        end
    end

    // Dataset storage; writes only while no run is in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < samples; s++) begin
                for (int i = 0; i < inputs; i++)  ds_values_r[s][i]   <= 0.0;
                for (int o = 0; o < outputs; o++) ds_expected_r[s][o] <= 0.0;
            end
        end else if (load_ok_s) begin
            for (int i = 0; i < inputs; i++)  ds_values_r[load_idx[sidx_w-1:0]][i]   <= load_values[i];
            for (int o = 0; o < outputs; o++) ds_expected_r[load_idx[sidx_w-1:0]][o] <= load_expected[o];
        end else begin
            ds_values_r <= ds_values_r;
        end
    end

    // Sample presentation: the MLP inputs change only on entry to PRESENT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < inputs; i++)  mlp_values[i]   <= 0.0;
            for (int o = 0; o < outputs; o++) mlp_expected[o] <= 0.0;
        end else if (enter_present_s) begin
            for (int i = 0; i < inputs; i++)  mlp_values[i]   <= ds_values_r[present_idx_s][i];
            for (int o = 0; o < outputs; o++) mlp_expected[o] <= ds_expected_r[present_idx_s][o];
        end else begin
            mlp_values <= mlp_values;
        end
    end

    // Run sequencer with registered status, pulse and loss outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r           <= IDLE;
            settle_r          <= '0;
            epochs_r          <= 16'd0;
            train_en_r        <= 1'b0;
            acc_r             <= 0.0;
            mlp_training      <= 1'b0;
            mlp_learning_rate <= 0.0;
            busy              <= 1'b0;
            done              <= 1'b0;
            sample_idx        <= '0;
            epoch_count       <= 16'd0;
            epoch_loss        <= 0.0;
            loss_valid        <= 1'b0;
        end else begin
            done         <= 1'b0;
            loss_valid   <= 1'b0;
            mlp_training <= 1'b0;
            if (enter_present_s) begin
                settle_r <= cnt_w'(settle_cycles - 1);
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        epochs_r          <= epochs;
                        train_en_r        <= train_en;
                        mlp_learning_rate <= lr_in;
                        epoch_count       <= 16'd0;
                        acc_r             <= 0.0;
                        sample_idx        <= '0;
                        busy              <= 1'b1;
                        state_r           <= (epochs == 16'd0) ? EPOCH_END : PRESENT;
                    end
                end
                PRESENT: begin
                    if (settle_r == '0) begin
                        state_r <= CAPTURE;
                    end else begin
                        settle_r <= settle_r - cnt_w'(1);
                    end
                end
                CAPTURE: begin
                    acc_r <= acc_r + capture_sum_s;
                    if (train_en_r) begin
                        mlp_training <= 1'b1;
                        state_r      <= UPDATE;
                    end else begin
                        state_r <= ADVANCE;
                    end
                end
                UPDATE: begin
                    state_r <= ADVANCE;
                end
                ADVANCE: begin
                    if (last_sample_s) begin
                        state_r <= EPOCH_END;
                    end else begin
                        sample_idx <= present_idx_s;
                        state_r    <= PRESENT;
                    end
                end
                EPOCH_END: begin
                    if (epochs_r == 16'd0) begin
                        epoch_loss <= 0.0;
                    end else begin
                        epoch_loss <= acc_r / real'(samples * outputs);
                        loss_valid <= 1'b1;
                    end
                    if (epoch_count != 16'hFFFF) begin
                        epoch_count <= epoch_count + 16'd1;
                    end
                    acc_r      <= 0.0;
                    sample_idx <= '0;
                    if (epochs_done_s) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= PRESENT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_trainer.sv
// Directed bench for mlp_trainer using a stub MLP whose prediction is either a constant 0.5
// or a confident 0.9/0.1 guess, checking latency, pulse counts, presented samples and loss.
module tb_mlp_trainer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [2:0]  load_idx;
    real         load_values [2];
    real         load_expected [1];
    logic        start;
    logic [15:0] epochs;
    logic        train_en;
    real         lr_in;
    real         mlp_values [2];
    real         mlp_expected [1];
    logic        mlp_training;
    real         mlp_learning_rate;
    real         mlp_prediction [1];
    logic        busy;
    logic        done;
    logic [1:0]  sample_idx;
    logic [15:0] epoch_count;
    real         epoch_loss;
    logic        loss_valid;

    int tests = 0;
    int fails = 0;
    int pred_mode = 0;

    real ds_v [4][2];
    real ds_e [4];

    int   busy_tot = 0;
    int   train_tot = 0;
    int   train_bad = 0;
    int   lv_tot = 0;
    logic prev_train = 1'b0;

    typedef struct {
        logic train;
        int   ep;
        int   mode;
        real  loss;
        int   busy_c;
        int   train_c;
        int   lv_c;
        int   lat;
        int   ec;
    } vec_t;

    vec_t vecs [5];

    mlp_trainer dut (
        .clk               (clk),
        .rst               (rst),
        .load_en           (load_en),
        .load_idx          (load_idx),
        .load_values       (load_values),
        .load_expected     (load_expected),
        .start             (start),
        .epochs            (epochs),
        .train_en          (train_en),
        .lr_in             (lr_in),
        .mlp_values        (mlp_values),
        .mlp_expected      (mlp_expected),
        .mlp_training      (mlp_training),
        .mlp_learning_rate (mlp_learning_rate),
        .mlp_prediction    (mlp_prediction),
        .busy              (busy),
        .done              (done),
        .sample_idx        (sample_idx),
        .epoch_count       (epoch_count),
        .epoch_loss        (epoch_loss),
        .loss_valid        (loss_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (pred_mode == 0) mlp_prediction[0] = 0.5;
        else if (mlp_expected[0] > 0.5) mlp_prediction[0] = 0.9;
        else mlp_prediction[0] = 0.1;
    end

    always @(negedge clk) begin
        if (busy) busy_tot++;
        if (loss_valid) lv_tot++;
        if (mlp_training) begin
            train_tot++;
            if (prev_train) train_bad++;
            if (mlp_values[0] != ds_v[sample_idx][0] || mlp_values[1] != ds_v[sample_idx][1]
                || mlp_expected[0] != ds_e[sample_idx]) train_bad++;
        end
        prev_train = mlp_training;
    end

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_real(input string name, input real act, input real exp, input real tol);
        real d;
        tests++;
        d = act - exp;
        if (d < 0.0) d = -d;
        if (d > tol) begin
            fails++;
            $display("FAIL %s: got %f, expected %f", name, act, exp);
        end
    endtask

    task automatic load(input int idx, input real a, input real b, input real e, input logic upd);
        @(negedge clk);
        load_en = 1'b1;
        load_idx = 3'(idx);
        load_values[0] = a;
        load_values[1] = b;
        load_expected[0] = e;
        @(negedge clk);
        load_en = 1'b0;
        if (upd) begin
            ds_v[idx][0] = a;
            ds_v[idx][1] = b;
            ds_e[idx] = e;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag, input logic inject);
        int b0, t0, tb0, l0, lat, ec_at, busy_at, trn_at;
        logic got;
        real loss_at, lr_at;
        b0 = busy_tot; t0 = train_tot; tb0 = train_bad; l0 = lv_tot;
        pred_mode = v.mode;
        @(negedge clk);
        start = 1'b1;
        epochs = 16'(v.ep);
        train_en = v.train;
        lr_in = 0.25;
        lat = 0;
        got = 1'b0;
        ec_at = 0; busy_at = 0; trn_at = 0; loss_at = 0.0; lr_at = 0.0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            start = 1'b0;
            load_en = 1'b0;
            lat++;
            if (done) begin
                got = 1'b1;
                ec_at = int'(epoch_count);
                busy_at = int'(busy);
                trn_at = int'(mlp_training);
                loss_at = epoch_loss;
                lr_at = mlp_learning_rate;
            end else if (inject && lat == 5) begin
                load_en = 1'b1;
                load_idx = 3'd0;
                load_values[0] = 7.0;
                load_values[1] = 7.0;
                load_expected[0] = 1.0;
                start = 1'b1;
                epochs = 16'd5;
                train_en = 1'b0;
            end
        end
        chk_int({tag, " done_seen"}, int'(got), 1);
        chk_int({tag, " latency"}, lat, v.lat);
        chk_int({tag, " busy_at_done"}, busy_at, 0);
        chk_int({tag, " training_at_done"}, trn_at, 0);
        chk_real({tag, " epoch_loss"}, loss_at, v.loss, 1.0e-6);
        chk_real({tag, " learning_rate"}, lr_at, 0.25, 1.0e-12);
        if (v.ec >= 0) chk_int({tag, " epoch_count"}, ec_at, v.ec);
        @(negedge clk);
        chk_int({tag, " done_width"}, int'(done), 0);
        chk_int({tag, " busy_cycles"}, busy_tot - b0, v.busy_c);
        chk_int({tag, " training_pulses"}, train_tot - t0, v.train_c);
        chk_int({tag, " training_sample_errors"}, train_bad - tb0, 0);
        chk_int({tag, " loss_valid_pulses"}, lv_tot - l0, v.lv_c);
    endtask

    initial begin
        int l0;
        vecs[0] = '{1'b0, 1, 0, 0.6931472, 17, 0,  1, 18, 1};
        vecs[1] = '{1'b0, 0, 0, 0.0,        1, 0,  0,  2, -1};
        vecs[2] = '{1'b1, 3, 0, 0.6931472, 63, 12, 3, 64, 3};
        vecs[3] = '{1'b0, 2, 1, 0.1053605, 34, 0,  2, 35, 2};
        vecs[4] = '{1'b1, 1, 0, 0.6931472, 21, 4,  1, 22, 1};
        for (int s = 0; s < 4; s++) begin
            ds_v[s][0] = 0.0; ds_v[s][1] = 0.0; ds_e[s] = 0.0;
        end

        rst = 1'b0; load_en = 1'b0; load_idx = 3'd0; start = 1'b0;
        epochs = 16'd0; train_en = 1'b0; lr_in = 0.0;
        load_values[0] = 0.0; load_values[1] = 0.0; load_expected[0] = 0.0;
        #12;
        chk_int("reset busy", int'(busy), 0);
        chk_int("reset done", int'(done), 0);
        chk_int("reset epoch_count", int'(epoch_count), 0);
        chk_int("reset training", int'(mlp_training), 0);
        chk_real("reset epoch_loss", epoch_loss, 0.0, 0.0);
        chk_real("reset mlp_values", mlp_values[1], 0.0, 0.0);
        @(negedge clk);
        rst = 1'b1;

        load(0, 0.0, 0.0, 0.0, 1'b1);
        load(1, 0.0, 1.0, 1.0, 1'b1);
        load(2, 1.0, 0.0, 1.0, 1'b1);
        load(3, 1.0, 1.0, 0.0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        // load and start during a run must be ignored
        run_vec(vecs[4], "busy_ignore", 1'b1);
        // out-of-range index must not touch any entry
        load(4, 9.0, 9.0, 1.0, 1'b0);
        run_vec(vecs[2], "oob_load", 1'b0);

        // asynchronous reset while sample 1 is being presented
        pred_mode = 0;
        l0 = lv_tot;
        @(negedge clk);
        start = 1'b1; epochs = 16'd3; train_en = 1'b1; lr_in = 0.25;
        repeat (7) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk_int("pre_reset sample_idx", int'(sample_idx), 1);
        chk_real("pre_reset mlp_values", mlp_values[1], 1.0, 0.0);
        #2 rst = 1'b0;
        #1;
        chk_int("midrun busy", int'(busy), 0);
        chk_int("midrun sample_idx", int'(sample_idx), 0);
        chk_real("midrun mlp_values", mlp_values[1], 0.0, 0.0);
        chk_real("midrun mlp_expected", mlp_expected[0], 0.0, 0.0);
        chk_real("midrun learning_rate", mlp_learning_rate, 0.0, 0.0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_int("post_reset idle busy", int'(busy), 0);
        chk_int("post_reset loss_valid", lv_tot - l0, 0);
        for (int s = 0; s < 4; s++) begin
            ds_v[s][0] = 0.0; ds_v[s][1] = 0.0; ds_e[s] = 0.0;
        end
        run_vec(vecs[4], "cleared_dataset", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
